// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg
// Shared definitions for the data memory responder: access size encodings,
// FSM state type, and helpers for the alignment check and the store lane merge.
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Illegal size or a lane offset not aligned to the access size.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: access_fault = 1'b0;
      SZ_HALF: access_fault = lane[0];
      SZ_WORD: access_fault = (lane != 2'b00);
      default: access_fault = 1'b1;
    endcase
  endfunction

  // Replace only the addressed lanes of old_word with the low bits of wdata.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      SZ_BYTE: w[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: w = wdata;
      default: w = old_word;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
// Request/response bus between a load/store requester (master) and the
// data memory responder (slave).
//   req_valid/req_ready  request handshake
//   req_we, req_addr, req_size, req_unsigned, req_wdata  request fields
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   response fields
//   err_inject           only when DMEM_PARITY_EN is defined
interface data_mem_responder_if #(parameter int AW = 7) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
`ifdef DMEM_PARITY_EN
  logic          err_inject;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready, err_inject,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready, err_inject,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`endif
endinterface

// File: rtl/data_mem_responder_load_align.sv
// data_mem_responder_load_align
// Combinational load formatter: picks the addressed byte/half/word out of a
// memory word and sign- or zero-extends it to 32 bits.
//   word  in   memory word
//   lane  in   byte offset addr[1:0]
//   size  in   access size encoding
//   uns   in   1 = zero-extend, 0 = sign-extend
//   data  out  formatted load data (0 for an illegal size)
module data_mem_responder_load_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    data   = '0;
    case (size)
      SZ_BYTE: data = {{24{~uns & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{16{~uns & half_v[15]}}, half_v};
      SZ_WORD: data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-port data memory that answers one load/store request at a time
// after a fixed number of wait states.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (also clears the memory)
//   bus    slave side of data_mem_responder_if
// Parameters: AW byte-address width (2**(AW-2) words), WAIT_STATES 0..15.
// Optional: DMEM_PARITY_EN adds per-word even parity and the err_inject input.
//
// state  | meaning
// S_IDLE | ready for a request; accept captures fields and loads the counter
// S_WAIT | counting wait states; access happens on the edge the count hits 0
// S_RESP | response held until rsp_ready
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int AW          = 7,
  parameter int WAIT_STATES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int         WORDS = 2 ** (AW - 2);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t        state;
  logic [3:0]    cnt;
  logic          req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic          c_we, c_uns;
  logic [AW-1:0] c_addr;
  logic [1:0]    c_size;
  logic [31:0]   c_wdata;

  logic [31:0]   mem [WORDS];

  // Access fields: straight from the bus when the access happens on the
  // accept edge (WAIT_STATES = 0), otherwise from the captured copy.
  logic          a_we, a_uns, a_inj;
  logic [AW-1:0] a_addr;
  logic [1:0]    a_size, lane;
  logic [31:0]   a_wdata, rd_word, ld_data, wr_word, acc_rdata;
  logic [AW-3:0] idx;
  logic          access_now, fault, par_bad, wr_en, acc_err;

`ifdef DMEM_PARITY_EN
  logic          c_inj;
  logic [WORDS-1:0] par;
`endif

  always_comb begin
    if (state == S_IDLE) begin
      a_we    = bus.req_we;
      a_uns   = bus.req_unsigned;
      a_addr  = bus.req_addr;
      a_size  = bus.req_size;
      a_wdata = bus.req_wdata;
    end else begin
      a_we    = c_we;
      a_uns   = c_uns;
      a_addr  = c_addr;
      a_size  = c_size;
      a_wdata = c_wdata;
    end
`ifdef DMEM_PARITY_EN
    a_inj   = (state == S_IDLE) ? bus.err_inject : c_inj;
    par_bad = ((^rd_word) != par[idx]);
`else
    a_inj   = 1'b0;
    par_bad = 1'b0;
`endif
    idx        = a_addr[AW-1:2];
    lane       = a_addr[1:0];
    rd_word    = mem[idx];
    fault      = access_fault(a_size, lane);
    access_now = ((state == S_IDLE) && bus.req_valid && (WS == 4'd0)) ||
                 ((state == S_WAIT) && (cnt == 4'd1));
    wr_en      = access_now && a_we && !fault;
    wr_word    = store_merge(rd_word, a_wdata, a_size, lane);
    acc_err    = fault || (!a_we && par_bad);
    acc_rdata  = (acc_err || a_we) ? 32'd0 : ld_data;
  end

  data_mem_responder_load_align u_load_align (
    .word (rd_word),
    .lane (lane),
    .size (a_size),
    .uns  (a_uns),
    .data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      c_we        <= 1'b0;
      c_uns       <= 1'b0;
      c_addr      <= '0;
      c_size      <= SZ_BYTE;
      c_wdata     <= '0;
`ifdef DMEM_PARITY_EN
      c_inj       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            c_we        <= bus.req_we;
            c_uns       <= bus.req_unsigned;
            c_addr      <= bus.req_addr;
            c_size      <= bus.req_size;
            c_wdata     <= bus.req_wdata;
`ifdef DMEM_PARITY_EN
            c_inj       <= bus.err_inject;
`endif
            cnt         <= WS;
            req_ready_q <= 1'b0;
            if (WS == 4'd0) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= acc_rdata;
              rsp_err_q   <= acc_err;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= acc_rdata;
            rsp_err_q   <= acc_err;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
`ifdef DMEM_PARITY_EN
      par <= '0;
`endif
    end else if (wr_en) begin
      mem[idx] <= wr_word;
`ifdef DMEM_PARITY_EN
      // Even parity; err_inject deliberately stores the wrong sense.
      par[idx] <= (^wr_word) ^ a_inj;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed scoreboard bench: the driver pushes the expected response for each
// request; the monitor pops and compares when a response appears and keeps
// comparing while it is held.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int AW = 7;
  localparam int WS = 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.AW(AW)) bus ();

  data_mem_responder #(.AW(AW), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin : monitor
    exp_t cur;
    logic shown;
    shown = 1'b0;
    cur   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) begin
        if (!shown) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rdata 0x%08h with no expected entry", bus.rsp_rdata);
          end else begin
            cur = exp_q.pop_front();
            check32("rsp_rdata", bus.rsp_rdata, cur.rdata);
            check32("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
          end
          shown = 1'b1;
        end else begin
          check32("hold_rdata", bus.rsp_rdata, cur.rdata);
          check32("hold_err", 32'(bus.rsp_err), 32'(cur.err));
        end
        check32("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
      end else begin
        shown = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input logic inj,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    int k;
    @(negedge clk);
    check32("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
`ifdef DMEM_PARITY_EN
    bus.err_inject   = inj;
`else
    if (inj) $display("note: err_inject ignored in this build");
`endif
    exp_q.push_back({exp_rdata, exp_err});
    @(posedge clk);
    #1;
    lat = 1;
    // Scramble the inputs after accept; the captured copy must be used.
    bus.req_valid    = 1'b0;
    bus.req_we       = ~we;
    bus.req_addr     = ~addr;
    bus.req_size     = ~size;
    bus.req_unsigned = ~uns;
    bus.req_wdata    = ~wdata;
`ifdef DMEM_PARITY_EN
    bus.err_inject   = ~inj;
`endif
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check32("latency", 32'(lat), 32'(WS + 1));
    if (bus.rsp_ready) begin
      k = 0;
      while (bus.rsp_valid === 1'b1 && k < 40) begin
        @(posedge clk);
        #1;
        k++;
      end
      check32("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin : main
    int k;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;
`ifdef DMEM_PARITY_EN
    bus.err_inject   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check32("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check32("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     we    addr    size     uns   wdata          inj   exp_rdata      exp_err
    do_req(1'b1, 7'h08, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0);
    do_req(1'b0, 7'h08, SZ_WORD, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 7'h0B, SZ_BYTE, 1'b0, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0);
    do_req(1'b0, 7'h0B, SZ_BYTE, 1'b1, 32'h0,        1'b0, 32'h000000DE, 1'b0);
    do_req(1'b1, 7'h09, SZ_BYTE, 1'b0, 32'hFFFFFF55, 1'b0, 32'h00000000, 1'b0);
    do_req(1'b0, 7'h08, SZ_WORD, 1'b0, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);
    do_req(1'b0, 7'h0A, SZ_HALF, 1'b0, 32'h0,        1'b0, 32'hFFFFDEAD, 1'b0);
    do_req(1'b0, 7'h08, SZ_HALF, 1'b1, 32'h0,        1'b0, 32'h000055EF, 1'b0);
    do_req(1'b0, 7'h08, SZ_BYTE, 1'b0, 32'h0,        1'b0, 32'hFFFFFFEF, 1'b0);
    do_req(1'b0, 7'h05, SZ_HALF, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b1);
    do_req(1'b1, 7'h0A, SZ_WORD, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1);
    do_req(1'b0, 7'h08, SZ_WORD, 1'b0, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);
    do_req(1'b0, 7'h08, SZ_ILL,  1'b0, 32'h0,        1'b0, 32'h00000000, 1'b1);
    do_req(1'b1, 7'h0E, SZ_HALF, 1'b0, 32'h1234ABCD, 1'b0, 32'h00000000, 1'b0);
    do_req(1'b0, 7'h0C, SZ_WORD, 1'b0, 32'h0,        1'b0, 32'hABCD0000, 1'b0);
    do_req(1'b1, 7'h0C, SZ_BYTE, 1'b0, 32'h00000080, 1'b0, 32'h00000000, 1'b0);
    do_req(1'b0, 7'h0C, SZ_BYTE, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 7'h0C, SZ_WORD, 1'b0, 32'h0,        1'b0, 32'hABCD0080, 1'b0);

    // Back-pressure: response held for 5 cycles, then released.
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 7'h08, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'hDEAD55EF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check32("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check32("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check32("release_req_ready", 32'(bus.req_ready), 32'd1);

    // Reset during WAIT abandons a pending store.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 7'h10;
    bus.req_size  = SZ_WORD;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check32("in_wait_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check32("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check32("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check32("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check32("midrst_rsp_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 7'h10, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b0);
    do_req(1'b0, 7'h08, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b0);

    // Parity error injection.
    do_req(1'b1, 7'h04, SZ_WORD, 1'b0, 32'h00000001, 1'b1, 32'h00000000, 1'b0);
`ifdef DMEM_PARITY_EN
    do_req(1'b0, 7'h04, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b1);
    do_req(1'b1, 7'h04, SZ_WORD, 1'b0, 32'h00000003, 1'b0, 32'h00000000, 1'b0);
    do_req(1'b0, 7'h04, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h00000003, 1'b0);
`else
    do_req(1'b0, 7'h04, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h00000001, 1'b0);
`endif

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    check32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter AW, default 7, byte-address width; word count = 2**(AW-2).
REQ-002 SHALL have parameter WAIT_STATES, default 1, cycles between request accept and memory access (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  load/store request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  AW  byte address.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_wdata  input  32  store data, LSB-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  requester accepts response.
REQ-014 rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  output  1  access error flag, valid with rsp_valid.
REQ-016 err_inject  input  1  present only with DMEM_PARITY_EN; see REQ-033.

Function
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 IDLE: req_ready=1; on req_valid capture all req_* fields and load wait counter with WAIT_STATES.
REQ-019 IDLE to WAIT on accept when WAIT_STATES>0; IDLE to RESP on accept when WAIT_STATES=0, access performed at that edge.
REQ-020 WAIT: req_ready=0; counter decrements each cycle; at the edge where counter reaches 0, perform access and go to RESP.
REQ-021 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on rsp_ready go to IDLE. A new request is not accepted in the same cycle.
REQ-022 Request-to-response latency: WAIT_STATES+1 cycles from accept edge to rsp_valid high.
REQ-023 Word index = addr[AW-1:2]; byte lane = addr[1:0].
REQ-024 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11: rsp_err=1, no memory write, rsp_rdata=0.
REQ-025 Store byte/half writes only the addressed lanes from req_wdata[7:0]/[15:0]; other lanes unchanged.
REQ-026 Load extracts addressed lane and extends per req_unsigned.
REQ-027 Captured request fields are unaffected by input changes after accept.

Reset
REQ-028 Asserting rst_n low at any time forces IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-029 All memory words (and parity bits) reset to 0.
REQ-030 Reset during WAIT or RESP abandons the transaction; a pending store is not written.

Configuration
REQ-031 Macro DMEM_PARITY_EN compiles in per-word even parity storage and checking.
REQ-032 With DMEM_PARITY_EN: every write recomputes the word's parity; a load with parity mismatch sets rsp_err=1 and rsp_rdata=0.
REQ-033 With DMEM_PARITY_EN: err_inject=1 at accept of a store stores inverted parity.
REQ-034 Without DMEM_PARITY_EN: no parity storage, no err_inject port; rsp_err reflects REQ-024 only.

Structure
REQ-035 Shared package holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-036 Single sub-module load_align: combinational lane extraction and sign/zero extension for loads.

Verification
REQ-037 Reset, store word 0xDEADBEEF at 0x08, load word 0x08 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept (WAIT_STATES=1).
REQ-038 After REQ-037, load byte signed at 0x0B -> 0xFFFFFFDE; unsigned -> 0x000000DE; store byte 0x55 at 0x09 then load word 0x08 -> 0xDEAD55EF.
REQ-039 Load half at 0x05 -> rsp_err=1, rsp_rdata=0; store word at 0x0A -> rsp_err=1, word 0x08 unchanged.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-041 Store word 0x12345678 at 0x10, drop rst_n during WAIT -> outputs reset immediately; load word 0x10 -> 0x00000000.
REQ-042 With DMEM_PARITY_EN: store 0x1 at 0x04 with err_inject=1, load word 0x04 -> rsp_err=1, rsp_rdata=0; without macro same store/load -> 0x00000001, rsp_err=0.
